coord_packet_deframer: RTL and testbench

Parametrised UART coordinate-packet deframer for the camera link. Consumes the byte stream from the UART receiver (one byte per data-ready strobe) and hunts for a run of 0xFF sync bytes. It then unpacks NUM_POINTS packed 12-bit (x,y) pairs into registered output arrays. Sits between the receiver and the hand-tracking/game logic on camera 1, replacing ad-hoc shift-buffer decoding; adds an inter-byte timeout, frame/error statistics and atomic output update.

---
 rtl/coord_packet_deframer.sv | 159 +++++++++++++++
 tb/tb_coord_packet_deframer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coord_packet_deframer.sv
// UART coordinate-packet deframer: hunts for a 0xFF sync run, then unpacks NUM_POINTS 12-bit (x,y) pairs.
// Define CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
//
// state   | meaning
// HUNT    | counting consecutive 0xFF bytes, waiting for a full header
// PAYLOAD | collecting 3*NUM_POINTS payload bytes into the shadow buffer
// CHECK   | waiting for the XOR checksum byte (CHECKSUM_EN builds only)
module coord_packet_deframer #(
    parameter int NUM_POINTS     = 2,
    parameter int SYNC_LEN       = 3,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    input  logic                      clr_stats_in,
    output logic [12*NUM_POINTS-1:0]  x_out,
    output logic [12*NUM_POINTS-1:0]  y_out,
    output logic                      frame_valid_out,
    output logic                      busy_out,
    output logic [15:0]               frame_count_out,
    output logic [7:0]                err_count_out
);

    localparam int PAY_LEN = 3 * NUM_POINTS;
    localparam int IDX_W   = $clog2(PAY_LEN);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAY_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       SYNC_LAST = 3'(SYNC_LEN - 1);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
`ifdef CHECKSUM_EN
    localparam logic [1:0] ST_CHECK   = 2'd2;
    logic [7:0] csum;
`endif

    logic [1:0]              state, state_next;
    logic [2:0]              sync_cnt;
    logic [IDX_W-1:0]        idx;
    logic [TO_W-1:0]         to_cnt;
    logic [7:0]              pay      [PAY_LEN];
    logic [7:0]              pay_next [PAY_LEN];
    logic [12*NUM_POINTS-1:0] x_next, y_next;
    logic                    commit, bad, to_expire, last_byte;

    assign last_byte = (idx == IDX_LAST);
    assign to_expire = (state != ST_HUNT) && !byte_valid_in && (to_cnt == TO_LAST);

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        bad        = 1'b0;
        case (state)
            ST_HUNT: begin
                if (byte_valid_in && byte_in == 8'hFF && sync_cnt == SYNC_LAST)
                    state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (byte_valid_in) begin
                    if (last_byte) begin
`ifdef CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_HUNT;
                        commit     = 1'b1;
`endif
                    end
                end else if (to_expire) begin
                    state_next = ST_HUNT;
                    bad        = 1'b1;
                end
            end
`ifdef CHECKSUM_EN
            ST_CHECK: begin
                if (byte_valid_in) begin
                    state_next = ST_HUNT;
                    if (byte_in == csum) commit = 1'b1;
                    else                 bad    = 1'b1;
                end else if (to_expire) begin
                    state_next = ST_HUNT;
                    bad        = 1'b1;
                end
            end
`endif
            default: state_next = ST_HUNT;
        endcase
    end

    // The final payload byte is merged here so a commit on that same edge sees the whole frame.
    always_comb begin
        for (int i = 0; i < PAY_LEN; i++) pay_next[i] = pay[i];
        if (state == ST_PAYLOAD && byte_valid_in) pay_next[idx] = byte_in;
        x_next = '0;
        y_next = '0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            x_next[12*i +: 12] = {pay_next[3*i], pay_next[3*i+1][7:4]};
            y_next[12*i +: 12] = {pay_next[3*i+1][3:0], pay_next[3*i+2]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_HUNT;
            sync_cnt        <= '0;
            idx             <= '0;
            to_cnt          <= '0;
            for (int i = 0; i < PAY_LEN; i++) pay[i] <= '0;
            x_out           <= '0;
            y_out           <= '0;
            frame_valid_out <= 1'b0;
            busy_out        <= 1'b0;
            frame_count_out <= '0;
            err_count_out   <= '0;
`ifdef CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            state           <= state_next;
            busy_out        <= (state_next != ST_HUNT);
            frame_valid_out <= commit;
            for (int i = 0; i < PAY_LEN; i++) pay[i] <= pay_next[i];

            if (commit) begin
                x_out <= x_next;
                y_out <= y_next;
            end

            if (state == ST_HUNT && byte_valid_in) begin
                if (byte_in != 8'hFF || sync_cnt == SYNC_LAST) sync_cnt <= '0;
                else                                          sync_cnt <= sync_cnt + 1'b1;
            end

            if (state == ST_HUNT)                       idx <= '0;
            else if (state == ST_PAYLOAD && byte_valid_in) idx <= last_byte ? '0 : idx + 1'b1;

            // Idle time only accrues inside a frame; any strobe restarts it.
            if (state == ST_HUNT || byte_valid_in || to_expire) to_cnt <= '0;
            else                                                 to_cnt <= to_cnt + 1'b1;

`ifdef CHECKSUM_EN
            if (state == ST_HUNT)                          csum <= '0;
            else if (state == ST_PAYLOAD && byte_valid_in) csum <= csum ^ byte_in;
`endif

            if (clr_stats_in) begin
                frame_count_out <= '0;
                err_count_out   <= '0;
            end else begin
                if (commit)                         frame_count_out <= frame_count_out + 1'b1;
                if (bad && err_count_out != 8'hFF)  err_count_out   <= err_count_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coord_packet_deframer.sv
// Bench for coord_packet_deframer: queue-based reference model checked every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_coord_packet_deframer;

    localparam int NP = 2;
    localparam int SL = 3;
    localparam int TO = 20;
    localparam int PL = 3 * NP;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        clr_stats_in;
    logic [23:0] x_out, y_out;
    logic        frame_valid_out, busy_out;
    logic [15:0] frame_count_out;
    logic [7:0]  err_count_out;

    coord_packet_deframer #(.NUM_POINTS(NP), .SYNC_LEN(SL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .byte_in         (byte_in),
        .byte_valid_in   (byte_valid_in),
        .clr_stats_in    (clr_stats_in),
        .x_out           (x_out),
        .y_out           (y_out),
        .frame_valid_out (frame_valid_out),
        .busy_out        (busy_out),
        .frame_count_out (frame_count_out),
        .err_count_out   (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: header hunting by run length, payload as a byte queue, idle-time counting.
    bit              m_hunt;
    int              m_ff, m_idle;
    byte unsigned    m_pay[$];
    logic [23:0]     e_x, e_y;
    logic            e_fv, e_busy;
    logic [15:0]     e_fc;
    logic [7:0]      e_ec;
    bit              m_commit, m_bad;
    byte unsigned    m_xor;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_hunt = 1; m_ff = 0; m_idle = 0; m_pay.delete();
            e_x = '0; e_y = '0; e_fv = 0; e_busy = 0; e_fc = '0; e_ec = '0;
        end else begin
            m_commit = 0;
            m_bad    = 0;
            if (m_hunt) begin
                if (byte_valid_in) begin
                    if (byte_in == 8'hFF) begin
                        m_ff++;
                        if (m_ff == SL) begin
                            m_hunt = 0; m_ff = 0; m_idle = 0; m_pay.delete();
                        end
                    end else begin
                        m_ff = 0;
                    end
                end
            end else if (byte_valid_in) begin
                m_idle = 0;
                if (m_pay.size() < PL) begin
                    m_pay.push_back(byte_in);
`ifndef CHECKSUM_EN
                    if (m_pay.size() == PL) begin m_commit = 1; m_hunt = 1; end
`endif
                end else begin
                    m_xor = 0;
                    foreach (m_pay[k]) m_xor ^= m_pay[k];
                    if (byte_in == m_xor) m_commit = 1;
                    else                  m_bad    = 1;
                    m_hunt = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin m_bad = 1; m_hunt = 1; m_ff = 0; end
            end

            e_fv = m_commit;
            if (m_commit) begin
                for (int i = 0; i < NP; i++) begin
                    e_x[12*i +: 12] = 12'((int'(m_pay[3*i]) << 4) | (int'(m_pay[3*i+1]) >> 4));
                    e_y[12*i +: 12] = 12'(((int'(m_pay[3*i+1]) & 15) << 8) | int'(m_pay[3*i+2]));
                end
                e_fc = e_fc + 16'd1;
            end
            if (m_bad && e_ec != 8'hFF) e_ec = e_ec + 8'd1;
            if (clr_stats_in) begin e_fc = '0; e_ec = '0; end
            e_busy = !m_hunt;
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            check("model x_out", x_out, e_x);
            check("model y_out", y_out, e_y);
            check("model frame_valid", frame_valid_out, e_fv);
            check("model busy", busy_out, e_busy);
            check("model frame_count", frame_count_out, e_fc);
            check("model err_count", err_count_out, e_ec);
        end
    end

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid_in = 1'b1;
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic header();
        repeat (SL) send(8'hFF);
    endtask

    task automatic send_cks(input logic [7:0] c);
`ifdef CHECKSUM_EN
        send(c);
`else
        if (c == 8'h00) idle(0);
`endif
    endtask

    task automatic frame_123(); // 12 34 56 AB CD EF, XOR = F9
        header();
        send(8'h12); send(8'h34); send(8'h56);
        send(8'hAB); send(8'hCD); send(8'hEF);
        send_cks(8'hF9);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0; byte_in = '0; byte_valid_in = 1'b0; clr_stats_in = 1'b0;
        idle(2);
        check("reset x_out", x_out, 24'h0);
        check("reset y_out", y_out, 24'h0);
        check("reset frame_valid", frame_valid_out, 1'b0);
        check("reset busy", busy_out, 1'b0);
        check("reset frame_count", frame_count_out, 16'h0);
        check("reset err_count", err_count_out, 8'h0);
        rst_in = 1'b1;
        idle(2);

        frame_123();
        check("f1 x_out", x_out, 24'hABC123);
        check("f1 y_out", y_out, 24'hDEF456);
        check("f1 frame_valid", frame_valid_out, 1'b1);
        check("f1 frame_count", frame_count_out, 16'd1);
        idle(1);
        check("f1 pulse ends", frame_valid_out, 1'b0);
        idle(3);

        // Noise, false sync, then payload with FF FF FF treated as data.
        send(8'h00); send(8'hFF); send(8'hFF); send(8'h07);
        header();
        check("sync busy", busy_out, 1'b1);
        send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h01); send(8'h23); send(8'h45);
        send_cks(8'h98);
        check("noise x_out", x_out, 24'h012FFF);
        check("noise y_out", y_out, 24'h345FFF);
        check("noise frame_count", frame_count_out, 16'd2);
        idle(2);

        // Abandoned frame times out.
        header(); send(8'h11); send(8'h22);
        idle(25);
        check("timeout err_count", err_count_out, 8'd1);
        check("timeout x_out kept", x_out, 24'h012FFF);
        check("timeout busy", busy_out, 1'b0);

        // Byte on the would-be expiry cycle is accepted.
        header(); send(8'h33);
        idle(TO - 1);
        send(8'h44); send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        send_cks(8'hBB);
        check("edge x_out", x_out, 24'h667334);
        check("edge y_out", y_out, 24'h788455);
        check("edge err_count", err_count_out, 8'd1);
        idle(2);

`ifdef CHECKSUM_EN
        header();
        send(8'h12); send(8'h34); send(8'h56); send(8'hAB); send(8'hCD); send(8'hEF);
        send(8'h55);
        check("bad cks err_count", err_count_out, 8'd2);
        check("bad cks frame_valid", frame_valid_out, 1'b0);
        check("bad cks x_out kept", x_out, 24'h667334);
        idle(2);
`endif

        // Reset in the middle of a frame.
        header(); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        #2 rst_in = 1'b0;
        #1;
        check("midrst x_out", x_out, 24'h0);
        check("midrst y_out", y_out, 24'h0);
        check("midrst busy", busy_out, 1'b0);
        check("midrst frame_count", frame_count_out, 16'h0);
        check("midrst err_count", err_count_out, 8'h0);
        idle(2);
        rst_in = 1'b1;
        idle(1);
        frame_123();
        check("postrst x_out", x_out, 24'hABC123);
        check("postrst frame_count", frame_count_out, 16'd1);
        idle(2);

        // Error counter saturation.
        repeat (300) begin
            header();
            idle(TO + 1);
        end
        check("sat err_count", err_count_out, 8'hFF);
        header(); idle(TO + 1);
        check("sat err_count hold", err_count_out, 8'hFF);

        // Clear coinciding with a commit.
        header();
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D); send(8'h0E);
`ifdef CHECKSUM_EN
        send(8'h0F);
        clr_stats_in = 1'b1; send(8'h01); clr_stats_in = 1'b0;
`else
        clr_stats_in = 1'b1; send(8'h0F); clr_stats_in = 1'b0;
`endif
        check("clr frame_count", frame_count_out, 16'h0);
        check("clr err_count", err_count_out, 8'h0);
        check("clr frame_valid", frame_valid_out, 1'b1);
        check("clr x_out", x_out, 24'h0D00A0);
        check("clr y_out", y_out, 24'hE0FB0C);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
